// File: rtl/dm_ctrl.sv
// Data-memory controller: single-port word RAM behind an in-order store buffer with load forwarding.
// Latency: loads return registered rdata/rvalid one cycle after acceptance; stores retire to the buffer in zero cycles.
// Backpressure: stall (combinational) holds a store while the buffer is full, unless flush frees a slot that cycle.
module dm_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int BUF_DEPTH = 4,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         DM_CS,
    input  logic                         DM_R,
    input  logic                         DM_W,
    input  logic [31:0]                  addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rvalid,
    output logic                         stall,
    output logic                         err,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    input  logic                         flush,
    output logic                         drain_busy
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] idx;
    logic              unused_addr_bits;
    assign idx              = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] buf_idx_q [BUF_DEPTH];
    logic [DATA_W-1:0] buf_dat_q [BUF_DEPTH];

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic              is_load, is_store, is_illegal, full;
    logic              store_acc, drain_en;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_dat;
    logic [PW-1:0]     slot;

    assign is_load    = DM_CS & DM_R & ~DM_W;
    assign is_store   = DM_CS & DM_W & ~DM_R;
    assign is_illegal = DM_CS & DM_R & DM_W;
    assign full       = (cnt_q == CW'(BUF_DEPTH));

    // A flushed cycle pops the head on the same edge, so a store into a full buffer still fits.
    assign stall     = is_store & full & ~flush;
    assign store_acc = is_store & ~stall;
    assign drain_en  = (cnt_q != '0) & (~DM_CS | (flush & ~is_load & ~is_illegal));

    // Walk oldest to youngest so the youngest matching entry overrides earlier hits.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        slot    = '0;
        for (int k = 0; k < BUF_DEPTH; k++) begin
            slot = head_q + PW'(k);
            if ((CW'(k) < cnt_q) && (buf_idx_q[slot] == idx)) begin
                fwd_hit = 1'b1;
                fwd_dat = buf_dat_q[slot];
            end
        end
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = is_load;
        err_d    = is_illegal;
        if (store_acc) tail_d = tail_q + PW'(1);
        if (drain_en)  head_d = head_q + PW'(1);
        case ({store_acc, drain_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (is_load) rdata_d = fwd_hit ? fwd_dat : mem[idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Buffer payload and RAM need no reset; cnt_q is zero under reset, so no drain write can fire.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            buf_idx_q[tail_q] <= idx;
            buf_dat_q[tail_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (drain_en) mem[buf_idx_q[head_q]] <= buf_dat_q[head_q];
    end

    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign err        = err_q;
    assign buf_count  = cnt_q;
    assign drain_busy = (cnt_q != '0);
endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Data-memory controller directly downstream of the CPU core's data-memory port.
- Consumes the core's DM_CS / DM_R / DM_W strobes, addr and wdata; returns registered rdata.
- Single-port word RAM fronted by a small in-order store buffer with load forwarding.
- Stores retire to the buffer immediately; the buffer drains to RAM on idle bus cycles.

Parameters:
- ADDR_W, 8, word-index width; RAM depth = 2**ADDR_W words.
- BUF_DEPTH, 4, store-buffer entries (power of two, ≥2).
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- DM_CS  in  1  data-memory chip select.
- DM_R  in  1  load strobe.
- DM_W  in  1  store strobe.
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] and upper bits ignored.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load data, registered.
- rvalid  out  1  one-cycle pulse: rdata holds the result of the load accepted on the previous edge.
- stall  out  1  combinational; core must hold its request while this is high.
- err  out  1  registered one-cycle pulse on an illegal request.
- buf_count  out  $clog2(BUF_DEPTH)+1  store-buffer occupancy.
- flush  in  1  level; forces a drain every cycle the bus is not performing a load.
- drain_busy  out  1  high while buf_count != 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - rdata=0, rvalid=0, err=0, buf_count=0.
  - Head/tail pointers cleared; buffered stores are discarded, not written.
  - RAM contents are not reset.
- Request classes, sampled on the rising edge:
  - Load: DM_CS & DM_R & ~DM_W.
  - Store: DM_CS & DM_W & ~DM_R.
  - Illegal: DM_CS & DM_R & DM_W. No state change except err=1 on the next cycle.
  - DM_CS=0: idle.
- stall = store & (buf_count==BUF_DEPTH).
  - A stalled store is not accepted; it is accepted on the first edge after stall falls.
  - Loads never stall.
- Store accept:
  - {index, wdata} written at the tail; tail increments modulo BUF_DEPTH; buf_count+1.
- Drain:
  - Happens on any edge with buf_count>0 and bus idle (DM_CS=0), or with flush=1 and no load.
  - Head entry is written to RAM; head increments; buf_count-1.
  - At most one drain per cycle.
  - Store accept and drain on the same edge (flush with a store present): buf_count unchanged. This is legal even when full, because the pop frees the slot first. With flush=1, stall is qualified as store & full & ~flush.
- Load, fixed 1-cycle latency:
  - RAM is read synchronously at index.
  - In parallel, all valid buffer entries are compared against index. The youngest matching entry (closest to tail) wins and overrides the RAM data.
  - rdata and rvalid=1 are presented on the cycle after acceptance; rvalid is 0 otherwise.
  - rdata holds its last value when rvalid=0.
- Ordering: a drain and a load never share an edge, so the RAM port is single-use per cycle. A store followed by a load to the same index always returns the stored data, via forwarding or via RAM.
- Wrap-around: pointers wrap modulo BUF_DEPTH. Full and empty are distinguished by buf_count, not by pointer equality.
- drain_busy = (buf_count != 0), combinational from the registered count.
- Reset asserted mid-operation: takes effect immediately. In-flight rvalid is cleared, and no RAM write occurs on or after the reset edge.

Test Plan:
- Reset, then store 0xDEADBEEF to addr 0x10 and load 0x10 next cycle → rvalid=1 with rdata=0xDEADBEEF one cycle after the load (forwarded); buf_count=1.
- Four stores (addr 0x0, 0x4, 0x8, 0xC; data 1..4), then a fifth store with DM_CS held → stall=1 and buf_count=4. Drop DM_CS for 1 cycle → buf_count=3, the stalled store is accepted when reissued, and RAM[0]=1.
- Two stores to addr 0x20 (data 0xA, then 0xB), then a load of 0x20 → rdata=0xB (youngest wins). After idle drain, a load of 0x20 → rdata=0xB from RAM.
- DM_CS=DM_R=DM_W=1 for one cycle → err pulses for exactly 1 cycle; buf_count and rvalid unchanged.
- Fill the buffer, assert flush with continuous stores → no stall, buf_count stays 4, and the head entries reach RAM in order.
- Pull reset low mid-drain with buf_count=3 → buf_count=0 and rvalid=0 immediately. Later loads of the un-drained addresses return the pre-existing RAM data.
